sound_fx: RTL

- Downstream consumer of the game top's `o_eat`, `o_success` and `o_failure` outputs. Turns game events into short square-wave jingles on a single audio pin (buzzer/PWM pad).
- Runs on the VGA pixel clock next to the game core.
- Edge-detects the events, arbitrates by priority, and steps through a fixed note sequence, with one tone-period counter and one note-duration counter.

---
 rtl/sound_fx_if.sv | 25 ++
 rtl/sound_fx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sound_fx_if.sv
// sound_fx_if: game-event inputs and audio outputs of the jingle generator.
//   master : event source / audio sink (game top or bench)
//   slave  : sound_fx itself
//   i_eat, i_success, i_failure : event inputs (pulse or level)
//   i_mute                      : silences o_audio without touching sequencing
//   o_audio, o_busy, o_fx       : square wave, jingle active, active effect code
interface sound_fx_if;
   logic       i_eat;
   logic       i_success;
   logic       i_failure;
   logic       i_mute;
   logic       o_audio;
   logic       o_busy;
   logic [1:0] o_fx;

   modport master (
      output i_eat, i_success, i_failure, i_mute,
      input  o_audio, o_busy, o_fx
   );

   modport slave (
      input  i_eat, i_success, i_failure, i_mute,
      output o_audio, o_busy, o_fx
   );
endinterface

// File: rtl/sound_fx.sv
// sound_fx: turns game events into short square-wave jingles on one audio pin.
//   clk, rst_n : pixel clock, synchronous active-low reset
//   bus        : sound_fx_if.slave (event inputs, mute, audio/busy/fx outputs)
// Rising edges of the events are arbitrated failure > success > eat; the
// winner plays a fixed note sequence. A strictly higher priority edge (or a
// new eat during eat) restarts from note 0; anything else is dropped.
module sound_fx #(
   parameter int unsigned HP_W     = 16,
   parameter int unsigned NOTE_W   = 24,
   parameter int unsigned HP_LOW   = 24000,
   parameter int unsigned HP_MID   = 19000,
   parameter int unsigned HP_HIGH  = 16000,
   parameter int unsigned NOTE_LEN = 2500000
) (
   input  logic       clk,
   input  logic       rst_n,
   sound_fx_if.slave  bus
);

   generate
      if (HP_LOW < 2 || HP_MID < 2 || HP_HIGH < 2 || NOTE_LEN < 2) begin : g_chk_min
         $error("sound_fx: half-periods and NOTE_LEN must be >= 2");
      end
      if ((64'(HP_LOW) >> HP_W) != 0 || (64'(HP_MID) >> HP_W) != 0 ||
          (64'(HP_HIGH) >> HP_W) != 0) begin : g_chk_hp_w
         $error("sound_fx: half-period does not fit HP_W");
      end
      if ((64'(NOTE_LEN) >> NOTE_W) != 0) begin : g_chk_note_w
         $error("sound_fx: NOTE_LEN does not fit NOTE_W");
      end
   endgenerate

   typedef enum logic {IDLE, PLAY} state_t;

   localparam logic [1:0] FX_NONE = 2'd0;
   localparam logic [1:0] FX_EAT  = 2'd1;
   localparam logic [1:0] FX_SUCC = 2'd2;
   localparam logic [1:0] FX_FAIL = 2'd3;

   // Terminal counts (value - 1) so the compare is a plain equality.
   localparam logic [HP_W-1:0]   HP_LOW_M1  = HP_W'(HP_LOW - 1);
   localparam logic [HP_W-1:0]   HP_MID_M1  = HP_W'(HP_MID - 1);
   localparam logic [HP_W-1:0]   HP_HIGH_M1 = HP_W'(HP_HIGH - 1);
   localparam logic [NOTE_W-1:0] NOTE_M1    = NOTE_W'(NOTE_LEN - 1);

   state_t              state_q, state_d;
   logic [1:0]          fx_q, fx_d;
   logic [1:0]          idx_q, idx_d;
   logic [HP_W-1:0]     hp_cnt_q, hp_cnt_d;
   logic [NOTE_W-1:0]   note_cnt_q, note_cnt_d;
   logic                audio_q, audio_d;
   logic                busy_q, busy_d;
   logic                eat_prev_q, eat_prev_d;
   logic                succ_prev_q, succ_prev_d;
   logic                fail_prev_q, fail_prev_d;

   logic                eat_rise, succ_rise, fail_rise;
   logic [1:0]          win;
   logic                accept;
   logic                is_last;
   logic [HP_W-1:0]     hp_m1;

   assign eat_rise  = bus.i_eat     & ~eat_prev_q;
   assign succ_rise = bus.i_success & ~succ_prev_q;
   assign fail_rise = bus.i_failure & ~fail_prev_q;

   always_comb begin
      win = FX_NONE;
      if (fail_rise)      win = FX_FAIL;
      else if (succ_rise) win = FX_SUCC;
      else if (eat_rise)  win = FX_EAT;
   end

   // Effect codes double as priority, so a numeric compare suffices.
   assign accept = (win != FX_NONE) &&
                   ((state_q == IDLE) || (win > fx_q) ||
                    (win == FX_EAT && fx_q == FX_EAT));

   assign is_last = (fx_q == FX_EAT) ? (idx_q == 2'd0) : (idx_q == 2'd2);

   // Half-period of the note currently playing.
   always_comb begin
      hp_m1 = HP_HIGH_M1;
      case (fx_q)
         FX_SUCC: case (idx_q)
                     2'd0:    hp_m1 = HP_LOW_M1;
                     2'd1:    hp_m1 = HP_MID_M1;
                     default: hp_m1 = HP_HIGH_M1;
                  endcase
         FX_FAIL: case (idx_q)
                     2'd0:    hp_m1 = HP_HIGH_M1;
                     2'd1:    hp_m1 = HP_MID_M1;
                     default: hp_m1 = HP_LOW_M1;
                  endcase
         default: hp_m1 = HP_HIGH_M1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      fx_d        = fx_q;
      idx_d       = idx_q;
      hp_cnt_d    = hp_cnt_q;
      note_cnt_d  = note_cnt_q;
      audio_d     = audio_q;
      eat_prev_d  = bus.i_eat;
      succ_prev_d = bus.i_success;
      fail_prev_d = bus.i_failure;

      if (accept) begin
         state_d    = PLAY;
         fx_d       = win;
         idx_d      = 2'd0;
         hp_cnt_d   = '0;
         note_cnt_d = '0;
         audio_d    = 1'b0;
      end else if (state_q == PLAY) begin
         if (note_cnt_q == NOTE_M1) begin
            note_cnt_d = '0;
            hp_cnt_d   = '0;
            audio_d    = 1'b0;
            if (is_last) begin
               state_d = IDLE;
               fx_d    = FX_NONE;
               idx_d   = 2'd0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end else begin
            note_cnt_d = note_cnt_q + 1'b1;
            if (hp_cnt_q == hp_m1) begin
               hp_cnt_d = '0;
               audio_d  = ~audio_q;
            end else begin
               hp_cnt_d = hp_cnt_q + 1'b1;
            end
         end
      end

      busy_d = (state_d == PLAY);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fx_q        <= FX_NONE;
         idx_q       <= 2'd0;
         hp_cnt_q    <= '0;
         note_cnt_q  <= '0;
         audio_q     <= 1'b0;
         busy_q      <= 1'b0;
         eat_prev_q  <= 1'b0;
         succ_prev_q <= 1'b0;
         fail_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fx_q        <= fx_d;
         idx_q       <= idx_d;
         hp_cnt_q    <= hp_cnt_d;
         note_cnt_q  <= note_cnt_d;
         audio_q     <= audio_d;
         busy_q      <= busy_d;
         eat_prev_q  <= eat_prev_d;
         succ_prev_q <= succ_prev_d;
         fail_prev_q <= fail_prev_d;
      end
   end

   // Mute gates only the pin; the sequencer keeps running underneath.
   assign bus.o_audio = audio_q & ~bus.i_mute;
   assign bus.o_busy  = busy_q;
   assign bus.o_fx    = fx_q;

endmodule
